// File: rtl/l1_i_controller_nway.sv
`default_nettype none
// ============================================================================
// Module   : l1_i_controller_nway
// Brief    : N-way set-associative L1 I-cache controller: tag/valid arrays,
//            per-set tree PLRU, L2 miss handshake, saturating hit/miss counters.
// Revision : 1.0
// ============================================================================
module l1_i_controller_nway #(
    parameter int TNUM   = 21,
    parameter int INUM   = 5,
    parameter int WAYS   = 4,
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = 26 - TNUM_2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TNUM-1:0]         tag_C_L1,
    input  logic [INUM-1:0]         index_C_L1,
    input  logic                    read_C_L1,
    input  logic                    flush,
    input  logic                    ready_L2_L1,
    output logic                    stall,
    output logic                    refill,
    output logic [$clog2(WAYS)-1:0] way,
    output logic                    read_L1_L2,
    output logic [INUM_2-1:0]       index_L1_L2,
    output logic [TNUM_2-1:0]       tag_L1_L2,
    output logic                    hit,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);

    localparam int SETS   = 2**INUM;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int NODES  = WAYS - 1;
    localparam int ADDR_W = TNUM + INUM;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MISS   = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [SETS-1:0][WAYS-1:0]        valid_q, valid_d;
    logic [SETS-1:0][NODES-1:0]       plru_q, plru_d;
    logic [TNUM-1:0]                  tag_mem_q [SETS][WAYS];
    logic [TNUM-1:0]                  mtag_q, mtag_d;
    logic [INUM-1:0]                  midx_q, midx_d;
    logic [WAY_W-1:0]                 victim_q, victim_d;
    logic [CNT_W-1:0]                 hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                 miss_cnt_q, miss_cnt_d;
    logic                             tag_we;

    logic                             lk_hit;
    logic [WAY_W-1:0]                 lk_way;
    logic                             inv_found;
    logic [WAY_W-1:0]                 inv_way;
    logic [WAY_W-1:0]                 plru_way;
    logic [ADDR_W-1:0]                miss_addr;

    // Tree bits are padded to WAYS so a WAY_W-bit node index always suffices.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] w);
        logic [WAYS-1:0]  tree;
        logic [WAY_W:0]   node;
        tree = {1'b0, bits};
        node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            tree[node[WAY_W-1:0]] = ~w[WAY_W-1-l];
            node = {node[WAY_W-1:0], 1'b1} + {{WAY_W{1'b0}}, w[WAY_W-1-l]};
        end
        return tree[NODES-1:0];
    endfunction

    always_comb begin
        logic [WAYS-1:0] tree;
        logic [WAY_W:0]  node;
        logic [WAY_W:0]  leaf;
        lk_hit    = 1'b0;
        lk_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[index_C_L1][w] && (tag_mem_q[index_C_L1][w] == tag_C_L1)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[index_C_L1][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        tree = {1'b0, plru_q[index_C_L1]};
        node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            node = {node[WAY_W-1:0], 1'b1} + {{WAY_W{1'b0}}, tree[node[WAY_W-1:0]]};
        end
        leaf     = node - (WAY_W+1)'(NODES);
        plru_way = leaf[WAY_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        plru_d     = plru_q;
        mtag_d     = mtag_q;
        midx_d     = midx_q;
        victim_d   = victim_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        tag_we     = 1'b0;
        stall      = 1'b0;
        hit        = 1'b0;
        refill     = 1'b0;
        way        = '0;
        read_L1_L2 = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    stall = 1'b1;
                end else if (read_C_L1) begin
                    if (lk_hit) begin
                        hit = 1'b1;
                        way = lk_way;
                        plru_d[index_C_L1] = plru_touch(plru_q[index_C_L1], lk_way);
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        stall    = 1'b1;
                        victim_d = inv_found ? inv_way : plru_way;
                        mtag_d   = tag_C_L1;
                        midx_d   = index_C_L1;
                        state_d  = S_MISS;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            S_MISS: begin
                stall      = 1'b1;
                read_L1_L2 = 1'b1;
                if (ready_L2_L1) state_d = S_REFILL;
            end
            S_REFILL: begin
                stall  = 1'b1;
                way    = victim_q;
                refill = ~flush;
                tag_we = 1'b1;
                valid_d[midx_q][victim_q] = 1'b1;
                plru_d[midx_q] = plru_touch(plru_q[midx_q], victim_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush overrides any lookup or refill decided above.
        if (flush) begin
            valid_d = '0;
            plru_d  = '0;
            state_d = S_IDLE;
            tag_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            plru_q     <= '0;
            mtag_q     <= '0;
            midx_q     <= '0;
            victim_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            plru_q     <= plru_d;
            mtag_q     <= mtag_d;
            midx_q     <= midx_d;
            victim_q   <= victim_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag storage needs no reset: entries are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (tag_we && !rst) tag_mem_q[midx_q][victim_q] <= mtag_q;
    end

    assign miss_addr   = {mtag_q, midx_q};
    assign index_L1_L2 = miss_addr[INUM_2-1:0];
    assign tag_L1_L2   = miss_addr[ADDR_W-1 -: TNUM_2];
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_i_controller_nway.sv
`default_nettype none
// Bench for l1_i_controller_nway: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based cache model.
module tb_l1_i_controller_nway;
    localparam int TNUM = 21, INUM = 5, WAYS = 4, TNUM_2 = 18, INUM_2 = 8, CNT_W = 4;
    localparam int SETS = 32;
    localparam int M_IDLE = 0, M_MISS = 1, M_REFILL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, read_C_L1, ready_L2_L1;
    logic [TNUM-1:0] tag_C_L1;
    logic [INUM-1:0] index_C_L1;
    logic stall, refill, read_L1_L2, hit;
    logic [1:0] way;
    logic [INUM_2-1:0] index_L1_L2;
    logic [TNUM_2-1:0] tag_L1_L2;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    l1_i_controller_nway #(.TNUM(TNUM), .INUM(INUM), .WAYS(WAYS), .TNUM_2(TNUM_2),
                           .INUM_2(INUM_2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .tag_C_L1(tag_C_L1), .index_C_L1(index_C_L1),
        .read_C_L1(read_C_L1), .flush(flush), .ready_L2_L1(ready_L2_L1),
        .stall(stall), .refill(refill), .way(way), .read_L1_L2(read_L1_L2),
        .index_L1_L2(index_L1_L2), .tag_L1_L2(tag_L1_L2), .hit(hit),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: per-way last-use timestamps; tree PLRU is the side away from the
    // most recently used way, applied recursively.
    logic            mvalid [SETS][WAYS];
    logic [TNUM-1:0] mtag   [SETS][WAYS];
    int unsigned     mts    [SETS][WAYS];
    int unsigned     stamp = 0;
    int              mst = M_IDLE, mvict = 0, hc = 0, mc = 0;
    logic [TNUM-1:0] mtagr = '0;
    logic [INUM-1:0] midxr = '0;
    bit              model_ok = 0;
    logic            e_stall = 1'b0;

    function automatic int m_lookup(input logic [INUM-1:0] s, input logic [TNUM-1:0] t);
        for (int w = 0; w < WAYS; w++) if (mvalid[s][w] && mtag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input logic [INUM-1:0] s);
        int lo, n, best;
        int unsigned bts;
        for (int w = 0; w < WAYS; w++) if (!mvalid[s][w]) return w;
        lo = 0; n = WAYS;
        while (n > 1) begin
            best = -1; bts = 0;
            for (int w = lo; w < lo + n; w++) if (mts[s][w] > bts) begin bts = mts[s][w]; best = w; end
            if (best >= 0 && best < lo + n/2) lo = lo + n/2;
            n = n / 2;
        end
        return lo;
    endfunction

    function automatic int sat(input int v);
        return (v == (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin mvalid[s][w] = 1'b0; mts[s][w] = 0; end
        mst = M_IDLE;
    endtask

    task automatic model_step();
        int hw;
        if (rst) begin
            m_clear();
            hc = 0; mc = 0; mvict = 0; mtagr = '0; midxr = '0;
            model_ok = 1;
            return;
        end
        if (!model_ok) return;
        if (flush) begin m_clear(); return; end
        case (mst)
            M_IDLE: if (read_C_L1) begin
                hw = m_lookup(index_C_L1, tag_C_L1);
                if (hw >= 0) begin
                    hc = sat(hc);
                    stamp++; mts[index_C_L1][hw] = stamp;
                end else begin
                    mvict = m_victim(index_C_L1);
                    mtagr = tag_C_L1; midxr = index_C_L1;
                    mc = sat(mc);
                    mst = M_MISS;
                end
            end
            M_MISS: if (ready_L2_L1) mst = M_REFILL;
            default: begin
                mtag[midxr][mvict] = mtagr;
                mvalid[midxr][mvict] = 1'b1;
                stamp++; mts[midxr][mvict] = stamp;
                mst = M_IDLE;
            end
        endcase
    endtask

    task automatic compare();
        int hw, e_way;
        logic e_hit, e_ref, e_rd;
        logic [25:0] fa;
        e_hit = 0; e_ref = 0; e_rd = 0; e_way = 0; e_stall = 0;
        case (mst)
            M_IDLE: begin
                if (flush) e_stall = 1;
                else if (read_C_L1) begin
                    hw = m_lookup(index_C_L1, tag_C_L1);
                    if (hw >= 0) begin e_hit = 1; e_way = hw; end
                    else e_stall = 1;
                end
            end
            M_MISS:  begin e_stall = 1; e_rd = 1; end
            default: begin e_stall = 1; e_ref = !flush; e_way = mvict; end
        endcase
        fa = {mtagr, midxr};
        check("stall", stall, e_stall);
        check("hit", hit, e_hit);
        check("refill", refill, e_ref);
        check("read_L1_L2", read_L1_L2, e_rd);
        if (e_hit || e_ref) check("way", way, e_way);
        check("tag_L1_L2", tag_L1_L2, fa >> INUM_2);
        check("index_L1_L2", index_L1_L2, fa % (1 << INUM_2));
        check("hit_cnt", hit_cnt, hc);
        check("miss_cnt", miss_cnt, mc);
    endtask

    initial forever begin @(posedge clk); model_step(); end
    initial forever begin @(negedge clk); if (model_ok) compare(); end

    // Issue one fetch and hold it until stall drops; L2 answers after dly miss cycles.
    task automatic fetch(input logic [TNUM-1:0] t, input logic [INUM-1:0] ix, input int dly,
                         output logic first_hit, output int first_way, output int rway,
                         output int nref, output int gap);
        int n, waited, rn;
        @(posedge clk); #1;
        tag_C_L1 = t; index_C_L1 = ix; read_C_L1 = 1; ready_L2_L1 = 0;
        @(negedge clk);
        first_hit = hit; first_way = int'(way);
        rway = -1; nref = 0; n = 0; waited = 0; rn = 0;
        while (stall && n < 200) begin
            if (refill) begin rway = int'(way); nref++; rn = n; end
            if (read_L1_L2) waited++;
            ready_L2_L1 = read_L1_L2 && (waited >= dly);
            @(negedge clk); n++;
        end
        ready_L2_L1 = 0;
        gap = n - rn;
        check("fetch_done", stall, 0);
        @(posedge clk); #1;
        read_C_L1 = 0;
    endtask

    initial begin
        logic fh;
        int fw, rw, nr, gp;
        rst = 1; flush = 0; read_C_L1 = 0; ready_L2_L1 = 0; tag_C_L1 = '0; index_C_L1 = '0;
        repeat (5) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_read_L1_L2", read_L1_L2, 0);
        check("rst_tag_L1_L2", tag_L1_L2, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);

        for (int t = 1; t <= 4; t++) begin
            fetch(TNUM'(t), 5'd3, 4, fh, fw, rw, nr, gp);
            check("cold_hit", fh, 0);
            check("cold_way", rw, t - 1);
            check("cold_refill_pulses", nr, 1);
            check("cold_stall_gap", gp, 1);
        end
        check("cold_miss_cnt", miss_cnt, 4);
        check("cold_hit_cnt", hit_cnt, 4);

        for (int t = 1; t <= 4; t++) begin
            fetch(TNUM'(t), 5'd3, 1, fh, fw, rw, nr, gp);
            check("hitpath_hit", fh, 1);
            check("hitpath_way", fw, t - 1);
            check("hitpath_no_refill", nr, 0);
        end
        check("hitpath_hit_cnt", hit_cnt, 8);
        check("hitpath_miss_cnt", miss_cnt, 4);

        fetch(21'h1, 5'd3, 1, fh, fw, rw, nr, gp);
        check("plru_touch_hit", fh, 1);
        fetch(21'h5, 5'd3, 2, fh, fw, rw, nr, gp);
        check("plru_victim", rw, 2);
        fetch(21'h3, 5'd3, 2, fh, fw, rw, nr, gp);
        check("plru_evicted_miss", fh, 0);

        @(posedge clk); #1;
        tag_C_L1 = 21'h7; index_C_L1 = 5'd5; read_C_L1 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("flush_pre_req", read_L1_L2, 1);
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0; read_C_L1 = 0; ready_L2_L1 = 1;
        @(negedge clk);
        check("flush_req_drop", read_L1_L2, 0);
        @(posedge clk); #1 ready_L2_L1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_no_refill", refill, 0);
        end
        fetch(21'h1, 5'd3, 1, fh, fw, rw, nr, gp);
        check("postflush_miss", fh, 0);
        check("postflush_way", rw, 0);

        for (int i = 0; i < 20; i++) fetch(21'h1, 5'd3, 1, fh, fw, rw, nr, gp);
        check("sat_hit_cnt", hit_cnt, 15);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 39) == 0);
            ready_L2_L1 = ($urandom_range(0, 2) == 0);
            if (!(read_C_L1 && e_stall)) begin
                read_C_L1 = ($urandom_range(0, 3) != 0);
                tag_C_L1 = TNUM'($urandom_range(1, 6));
                index_C_L1 = INUM'($urandom_range(0, 3));
            end
        end
        @(posedge clk); #1;
        rst = 0; flush = 0; read_C_L1 = 0; ready_L2_L1 = 0;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
